// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC iteration controller: state encoding,
// operating-mode constants and default iteration geometry.
package cordic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } cordic_state_e;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam int CORDIC_N_ITER = 16;
    localparam int CORDIC_ITER_W = 5;

endpackage

// File: rtl/cordic_iter_counter.sv
// Iteration index counter for the CORDIC controller; a clear wins over an
// increment so the controller can zero it while loading.
module cordic_iter_counter #(
    parameter int ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ITER_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ITER_W'(1);
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencing FSM for the iterative CORDIC datapath: load, N_ITER
// micro-rotations, result strobe, then completion held until acknowledged.
module cordic_iter_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int N_ITER = CORDIC_N_ITER,
    parameter int ITER_W = CORDIC_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic              ack_i,
    output logic              ready_o,
    output logic              load_init_o,
    output logic              iter_en_o,
    output logic [ITER_W-1:0] iter_idx_o,
    output logic              result_en_o,
    output logic              done_o,
    output logic              mode_o
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_LOAD  = LOAD;
    localparam logic [2:0] S_ITER  = ITER;
    localparam logic [2:0] S_FINAL = FINAL;
    localparam logic [2:0] S_DONE  = DONE;

    localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(N_ITER - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [ITER_W-1:0] count;
    logic              last_iter;
    logic              mode_q;

    assign last_iter = (count == LAST_IDX);

    // The terminal compare both exits ITER and freezes the counter at N_ITER-1.
    cordic_iter_counter #(
        .ITER_W (ITER_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_LOAD),
        .en    ((state == S_ITER) && !last_iter),
        .count (count)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_i)   state_next = S_LOAD;
            S_LOAD:                 state_next = S_ITER;
            S_ITER:  if (last_iter) state_next = S_FINAL;
            S_FINAL:                state_next = S_DONE;
            S_DONE:  if (ack_i)     state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mode_q <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && start_i) begin
                mode_q <= mode_i;
            end
        end
    end

    assign ready_o     = (state == S_IDLE);
    assign load_init_o = (state == S_LOAD);
    assign iter_en_o   = (state == S_ITER);
    assign result_en_o = (state == S_FINAL);
    assign done_o      = (state == S_DONE);
    assign iter_idx_o  = count;
    assign mode_o      = mode_q;

endmodule
